// File: rtl/lift_pkg.sv
// Shared types and sizing for the single-cabin elevator controller.
// Floors are numbered 0..NUM_FLOORS-1 and encoded in FLOOR_W bits.
package lift_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPEN,
    ST_EMERGENCY
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/lift_req_encoder.sv
// Combinational priority encoders: highest and lowest pending floor.
// Both outputs read 0 when no request is pending.
module lift_req_encoder
  import lift_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] i_requests,
  output logic [FLOOR_W-1:0]    o_max,
  output logic [FLOOR_W-1:0]    o_min
);

  always_comb begin
    o_max = '0;
    o_min = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_requests[i]) o_max = FLOOR_W'(i);
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (i_requests[i]) o_min = FLOOR_W'(i);
    end
  end

endmodule

// File: rtl/lift8.sv
// SCAN elevator controller for one cabin over 8 floors: latches requests,
// moves one floor per clock, holds the door for DOOR_CYCLES, supports e-stop.
module lift8
  import lift_pkg::*;
#(
  parameter int DOOR_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  emergency_stop,
  output logic                  idle,
  output logic                  door,
  output logic                  Up,
  output logic                  Down,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    max_request,
  output logic [FLOOR_W-1:0]    min_request,
  output logic [NUM_FLOORS-1:0] requests
);

  localparam int          TW        = (DOOR_CYCLES < 2) ? 1 : $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  dir_t                  r_dir;
  dir_t                  w_dir_nxt;
  logic [FLOOR_W-1:0]    r_floor;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic [FLOOR_W-1:0]    r_req_prev;
  logic                  r_first;
  logic [NUM_FLOORS-1:0] r_req;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [TW-1:0]         r_timer;
  logic [TW-1:0]         w_timer_nxt;
  logic [FLOOR_W-1:0]    w_max;
  logic [FLOOR_W-1:0]    w_min;
  logic [FLOOR_W-1:0]    w_up_floor;
  logic [FLOOR_W-1:0]    w_dn_floor;
  logic                  w_above;
  logic                  w_below;
  logic                  w_new;

  lift_req_encoder u_enc (
    .i_requests (r_req),
    .o_max      (w_max),
    .o_min      (w_min)
  );

  assign w_up_floor = r_floor + FLOOR_W'(1);
  assign w_dn_floor = r_floor - FLOOR_W'(1);
  assign w_above    = (r_req != '0) && (w_max > r_floor);
  assign w_below    = (r_req != '0) && (w_min < r_floor);

  // A request only counts when the input changes, so a held value latches once.
  assign w_new = r_first || (req_floor != r_req_prev);

  always_comb begin
    w_set = '0;
    if (w_new && !(r_state == ST_DOOR_OPEN && req_floor == r_floor)) begin
      w_set[req_floor] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_floor_nxt = r_floor;
    w_timer_nxt = r_timer;
    w_clr       = '0;
    if (emergency_stop) begin
      w_state_nxt = ST_EMERGENCY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_req[r_floor]) begin
            w_state_nxt     = ST_DOOR_OPEN;
            w_clr[r_floor]  = 1'b1;
            w_timer_nxt     = DOOR_LOAD;
          end else if (w_above && w_below) begin
            w_state_nxt = (r_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else if (w_above) begin
            w_state_nxt = ST_MOVE_UP;
            w_dir_nxt   = DIR_UP;
          end else if (w_below) begin
            w_state_nxt = ST_MOVE_DOWN;
            w_dir_nxt   = DIR_DOWN;
          end
        end
        ST_MOVE_UP: begin
          // Top floor guard keeps the floor counter from wrapping.
          if (r_floor == FLOOR_W'(NUM_FLOORS - 1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_floor_nxt = w_up_floor;
            if (r_req[w_up_floor]) begin
              w_state_nxt       = ST_DOOR_OPEN;
              w_clr[w_up_floor] = 1'b1;
              w_timer_nxt       = DOOR_LOAD;
            end
          end
        end
        ST_MOVE_DOWN: begin
          if (r_floor == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_floor_nxt = w_dn_floor;
            if (r_req[w_dn_floor]) begin
              w_state_nxt       = ST_DOOR_OPEN;
              w_clr[w_dn_floor] = 1'b1;
              w_timer_nxt       = DOOR_LOAD;
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (r_timer <= TW'(1)) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        ST_EMERGENCY: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_UP;
      r_floor    <= '0;
      r_req      <= '0;
      r_timer    <= '0;
      r_req_prev <= '0;
      r_first    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_floor    <= w_floor_nxt;
      r_req      <= (r_req | w_set) & ~w_clr;
      r_timer    <= w_timer_nxt;
      r_req_prev <= req_floor;
      r_first    <= 1'b0;
    end
  end

  assign idle          = (r_state == ST_IDLE);
  assign door          = (r_state == ST_DOOR_OPEN);
  assign Up            = (r_state == ST_MOVE_UP);
  assign Down          = (r_state == ST_MOVE_DOWN);
  assign current_floor = r_floor;
  assign requests      = r_req;
  assign max_request   = w_max;
  assign min_request   = w_min;

endmodule

// File: tb/tb_lift8.sv
// Directed bench for lift8: hand-computed state/floor/request vectors
// for each scenario, sampled 1 ns after the rising edge.
module tb_lift8;

  logic       clk;
  logic       reset;
  logic [2:0] req_floor;
  logic       emergency_stop;
  logic       idle;
  logic       door;
  logic       Up;
  logic       Down;
  logic [2:0] current_floor;
  logic [2:0] max_request;
  logic [2:0] min_request;
  logic [7:0] requests;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] F_IDLE = 4'b1000;
  localparam logic [3:0] F_DOOR = 4'b0100;
  localparam logic [3:0] F_UP   = 4'b0010;
  localparam logic [3:0] F_DN   = 4'b0001;
  localparam logic [3:0] F_NONE = 4'b0000;

  lift8 #(.DOOR_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_floor      (req_floor),
    .emergency_stop (emergency_stop),
    .idle           (idle),
    .door           (door),
    .Up             (Up),
    .Down           (Down),
    .current_floor  (current_floor),
    .max_request    (max_request),
    .min_request    (min_request),
    .requests       (requests)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [3:0] flags, input logic [2:0] fl,
                    input logic [7:0] rq);
    chk({tag, ".flags"}, 32'({idle, door, Up, Down}), 32'(flags));
    chk({tag, ".floor"}, 32'(current_floor), 32'(fl));
    chk({tag, ".req"},   32'(requests), 32'(rq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    req_floor      = 3'd0;
    emergency_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st("rst", F_IDLE, 3'd0, 8'h00);
    chk("rst.max", 32'(max_request), 32'd0);
    chk("rst.min", 32'(min_request), 32'd0);
    reset = 1'b1;

    // Held floor 0 after reset: latched once, served at floor 0.
    tick; st("t1.latch", F_IDLE, 3'd0, 8'h01);
    tick; st("t1.door0", F_DOOR, 3'd0, 8'h00);
    tick; st("t1.door1", F_DOOR, 3'd0, 8'h00);
    tick; st("t1.idle",  F_IDLE, 3'd0, 8'h00);

    // Floor 0 -> 3.
    req_floor = 3'd3;
    tick; st("t2.E0", F_IDLE, 3'd0, 8'h08);
    tick; st("t2.E1", F_UP,   3'd0, 8'h08);
    tick; st("t2.E2", F_UP,   3'd1, 8'h08);
    tick; st("t2.E3", F_UP,   3'd2, 8'h08);
    tick; st("t2.E4", F_DOOR, 3'd3, 8'h00);
    tick; st("t2.E5", F_DOOR, 3'd3, 8'h00);
    tick; st("t2.E6", F_IDLE, 3'd3, 8'h00);

    // Reach floor 4 going up, then requests 7 and 2 while the door is open.
    req_floor = 3'd4;
    tick; st("t3.l4",  F_IDLE, 3'd3, 8'h10);
    tick; st("t3.up",  F_UP,   3'd3, 8'h10);
    tick; st("t3.at4", F_DOOR, 3'd4, 8'h00);
    req_floor = 3'd7;
    tick; st("t3.l7",  F_DOOR, 3'd4, 8'h80);
    req_floor = 3'd2;
    tick; st("t3.l2",  F_IDLE, 3'd4, 8'h84);
    chk("t3.max", 32'(max_request), 32'd7);
    chk("t3.min", 32'(min_request), 32'd2);
    tick; st("t3.up4", F_UP,   3'd4, 8'h84);
    tick; st("t3.up5", F_UP,   3'd5, 8'h84);
    tick; st("t3.up6", F_UP,   3'd6, 8'h84);
    tick; st("t3.at7", F_DOOR, 3'd7, 8'h04);
    tick; st("t3.d7",  F_DOOR, 3'd7, 8'h04);
    tick; st("t3.i7",  F_IDLE, 3'd7, 8'h04);
    chk("t3.max2", 32'(max_request), 32'd2);
    chk("t3.min2", 32'(min_request), 32'd2);
    tick; st("t3.dn7", F_DN,   3'd7, 8'h04);
    for (int f = 6; f >= 3; f--) begin
      tick; st("t3.dn", F_DN, 3'(f), 8'h04);
    end
    tick; st("t3.at2", F_DOOR, 3'd2, 8'h00);
    tick; st("t3.d2",  F_DOOR, 3'd2, 8'h00);
    tick; st("t3.i2",  F_IDLE, 3'd2, 8'h00);

    // Go to 1, then 1 -> 6 with an intermediate stop at 4.
    req_floor = 3'd1;
    tick; st("t4.l1",  F_IDLE, 3'd2, 8'h02);
    tick; st("t4.dn",  F_DN,   3'd2, 8'h02);
    tick; st("t4.at1", F_DOOR, 3'd1, 8'h00);
    tick; st("t4.d1",  F_DOOR, 3'd1, 8'h00);
    tick; st("t4.i1",  F_IDLE, 3'd1, 8'h00);
    req_floor = 3'd6;
    tick; st("t4.l6",  F_IDLE, 3'd1, 8'h40);
    tick; st("t4.up1", F_UP,   3'd1, 8'h40);
    tick; st("t4.up2", F_UP,   3'd2, 8'h40);
    req_floor = 3'd4;
    tick; st("t4.up3", F_UP,   3'd3, 8'h50);
    tick; st("t4.at4", F_DOOR, 3'd4, 8'h40);
    tick; st("t4.d4",  F_DOOR, 3'd4, 8'h40);
    tick; st("t4.i4",  F_IDLE, 3'd4, 8'h40);
    tick; st("t4.up4", F_UP,   3'd4, 8'h40);
    tick; st("t4.up5", F_UP,   3'd5, 8'h40);
    tick; st("t4.at6", F_DOOR, 3'd6, 8'h00);
    tick; st("t4.d6",  F_DOOR, 3'd6, 8'h00);
    tick; st("t4.i6",  F_IDLE, 3'd6, 8'h00);

    // Down to floor 0 to set up the emergency scenario.
    req_floor = 3'd0;
    tick; st("t5.l0",  F_IDLE, 3'd6, 8'h01);
    tick; st("t5.dn6", F_DN,   3'd6, 8'h01);
    for (int f = 5; f >= 1; f--) begin
      tick; st("t5.dn", F_DN, 3'(f), 8'h01);
    end
    tick; st("t5.at0", F_DOOR, 3'd0, 8'h00);
    tick; st("t5.d0",  F_DOOR, 3'd0, 8'h00);
    tick; st("t5.i0",  F_IDLE, 3'd0, 8'h00);
    req_floor = 3'd5;
    tick; st("t5.l5",  F_IDLE, 3'd0, 8'h20);
    tick; st("t5.up0", F_UP,   3'd0, 8'h20);
    tick; st("t5.up1", F_UP,   3'd1, 8'h20);
    tick; st("t5.up2", F_UP,   3'd2, 8'h20);
    emergency_stop = 1'b1;
    req_floor      = 3'd3;
    tick; st("t5.em0", F_NONE, 3'd2, 8'h28);
    tick; st("t5.em1", F_NONE, 3'd2, 8'h28);
    tick; st("t5.em2", F_NONE, 3'd2, 8'h28);
    emergency_stop = 1'b0;
    tick; st("t5.rel", F_IDLE, 3'd2, 8'h28);
    tick; st("t5.res", F_UP,   3'd2, 8'h28);
    tick; st("t5.at3", F_DOOR, 3'd3, 8'h20);
    tick; st("t5.d3",  F_DOOR, 3'd3, 8'h20);
    tick; st("t5.i3",  F_IDLE, 3'd3, 8'h20);
    tick; st("t5.up3", F_UP,   3'd3, 8'h20);
    tick; st("t5.up4", F_UP,   3'd4, 8'h20);
    tick; st("t5.at5", F_DOOR, 3'd5, 8'h00);

    // A new request for the floor whose door is open is dropped.
    req_floor = 3'd5;
    tick; st("t5.disc", F_DOOR, 3'd5, 8'h00);
    tick; st("t5.i5",   F_IDLE, 3'd5, 8'h00);

    // Reset asserted mid MOVE_DOWN takes effect without a clock edge.
    req_floor = 3'd1;
    tick; st("t6.l1",  F_IDLE, 3'd5, 8'h02);
    tick; st("t6.dn5", F_DN,   3'd5, 8'h02);
    tick; st("t6.dn4", F_DN,   3'd4, 8'h02);
    #2;
    reset = 1'b0;
    #1;
    st("t6.rst", F_IDLE, 3'd0, 8'h00);
    chk("t6.max", 32'(max_request), 32'd0);
    chk("t6.min", 32'(min_request), 32'd0);
    tick;
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lift8.md
Name: lift8

Overview:
- Controller for a single 8-floor elevator (floors 0..7).
- Latches floor requests into a pending-request vector and moves one floor per clock.
- Serves requests with SCAN (keep direction while requests remain ahead), opens the door at each served floor, and supports an emergency stop.
- Leaf block under the building-control top level; drives status flags for the display/motor interface.

Parameters:
- DOOR_CYCLES, 2, number of clock cycles the door stays open at a served floor (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_floor  input  3  requested floor number, sampled every cycle
- emergency_stop  input  1  level-sensitive; 1 freezes motion
- idle  output  1  1 in IDLE state
- door  output  1  1 in DOOR_OPEN state
- Up  output  1  1 in MOVE_UP state
- Down  output  1  1 in MOVE_DOWN state
- current_floor  output  3  current cabin floor
- max_request  output  3  index of highest set bit of requests, 0 if none
- min_request  output  3  index of lowest set bit of requests, 0 if none
- requests  output  8  pending-request vector, bit i = floor i pending

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, current_floor=0, requests=0, last_dir=UP, door timer=0, req_prev=0, first-sample flag=1.
  - Outputs: idle=1, door=Up=Down=0, max_request=min_request=0.
- Request capture, every edge, all states including EMERGENCY:
  - A new request is recognised when req_floor != req_prev, or on the first cycle after reset.
  - req_prev <= req_floor each cycle; the first-sample flag clears after the first cycle.
  - A recognised request sets requests[req_floor].
  - Exception: a request for current_floor while in DOOR_OPEN is discarded.
  - A held constant req_floor registers only once.
- max_request/min_request: combinational priority encodes of requests.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERGENCY. Outputs are decoded from state only; EMERGENCY drives all four flags 0.
- IDLE, evaluated on registered requests:
  - If requests[current_floor] set: go to DOOR_OPEN, clear the bit, load the timer.
  - Else if requests pending above and below: continue last_dir.
  - Else if requests pending above only: MOVE_UP, last_dir=UP.
  - Else if requests pending below only: MOVE_DOWN, last_dir=DOWN.
  - Else: stay in IDLE.
- MOVE_UP, each edge:
  - current_floor <= current_floor+1.
  - If requests[current_floor+1] is set, go to DOOR_OPEN and clear that bit on the same edge.
  - Otherwise remain in MOVE_UP.
- MOVE_DOWN: symmetric, using -1.
- Floor never wraps: a move is only entered when a target exists in that direction, so floor 7 is never incremented and floor 0 never decremented.
- DOOR_OPEN:
  - Lasts exactly DOOR_CYCLES cycles, then IDLE.
  - IDLE then re-evaluates, giving a 1-cycle idle pulse between stops.
- Simultaneous set and clear of the same bit on one edge: clear wins.
- EMERGENCY:
  - emergency_stop=1 forces EMERGENCY on the next edge from any state; it overrides arrival and the door timer.
  - current_floor holds; requests keep latching.
  - When emergency_stop falls, go to IDLE on the next edge; the door timer is reset.
- Latency:
  - Request to movement start: 2 edges (latch, then IDLE decision).
  - Arrival to door=1: same edge as the arrival floor update.

Decomposition:
- Shared package lift_pkg:
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERGENCY)
  - NUM_FLOORS=8
  - FLOOR_W=3
- One natural sub-module: lift_req_encoder, combinational max/min priority encoder over requests.
- FSM, request register and door timer stay in lift8.

Test Plan:
- Reset then release, req_floor held 0:
  - First cycle latches floor 0.
  - Next edge goes to DOOR_OPEN; door=1 for 2 cycles, then idle=1, requests=8'h00, current_floor=0.
- At floor 0 idle, req_floor=3 (edge E0):
  - requests=8'h08 after E0; Up=1 after E1.
  - Floor becomes 1/2/3 at E2/E3/E4; door=1 from E4, requests=8'h00.
  - idle=1 after E6.
- Requests 7 and 2 from floor 4 while last_dir=UP (two consecutive cycles):
  - max_request=7, min_request=2.
  - Serves 7 first (Up), then Down to 2.
- Moving up from 1 toward 6, req 4 arrives before floor 4 is reached: door opens at floor 4, then continues to 6.
- emergency_stop=1 mid MOVE_UP at floor 2:
  - All flags 0, floor frozen at 2 for the whole pulse; requests still latch.
  - After release: idle for 1 cycle, then resumes Up.
- reset asserted during MOVE_DOWN: immediately current_floor=0, requests=0, idle=1.
